// File: rtl/store_trace_pkg.sv
// Shared types for the store trace monitor: verdict states and the trace entry layout.
package store_trace_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PASS = 2'd1,
    FAIL = 2'd2
  } verdict_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } trace_entry_t;

endpackage

// File: rtl/store_trace_monitor_fifo.sv
// Show-ahead trace FIFO with wrap-bit pointers; the head entry is read combinationally.
module trace_fifo
  import store_trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  trace_entry_t             wr_entry,
  output logic                     valid,
  output trace_entry_t             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  trace_entry_t mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         empty;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign valid   = ~empty;
  assign count   = wr_ptr - rd_ptr;
  assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Entry storage; contents need no reset because the pointers define what is live.
  always_ff @(posedge clk) begin
    if (!reset && do_push) begin
      mem[wr_ptr[AW-1:0]] <= wr_entry;
    end
  end

  // Pointer update; reset discards anything queued.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/store_trace_monitor.sv
// Watches processor stores, traces them into a FIFO and decides a pass/fail verdict.
//
// state | meaning
// RUN   | capturing stores, no verdict yet
// PASS  | PASS_DATA was stored at PASS_ADDR; terminal until reset
// FAIL  | a store hit anything other than SCRATCH_ADDR or the pass store; terminal
module store_trace_monitor
  import store_trace_pkg::*;
#(
  parameter int          DEPTH        = 8,
  parameter logic [31:0] PASS_ADDR    = 32'd84,
  parameter logic [31:0] PASS_DATA    = 32'd7,
  parameter logic [31:0] SCRATCH_ADDR = 32'd80
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     memwrite,
  input  logic [31:0]              dataadr,
  input  logic [31:0]              writedata,
  output logic                     trace_valid,
  input  logic                     trace_ready,
  output logic [31:0]              trace_addr,
  output logic [31:0]              trace_data,
  output logic [$clog2(DEPTH):0]   trace_count,
  output logic                     overflow,
  output logic [15:0]              store_count,
  output logic                     done,
  output logic                     pass
);

  verdict_state_t state;
  trace_entry_t   wr_entry;
  trace_entry_t   head;
  logic           capture;
  logic           fifo_full;
  logic           is_pass_store;

  // Once a verdict is reached, later stores are ignored completely.
  assign capture       = memwrite & (state == RUN);
  assign is_pass_store = (dataadr == PASS_ADDR) && (writedata == PASS_DATA);
  assign wr_entry      = '{addr: dataadr, data: writedata};
  assign trace_addr    = head.addr;
  assign trace_data    = head.data;

  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (capture),
    .pop      (trace_ready),
    .wr_entry (wr_entry),
    .valid    (trace_valid),
    .head     (head),
    .count    (trace_count),
    .full     (fifo_full)
  );

  // Verdict FSM with registered done/pass, plus store counter and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      done        <= 1'b0;
      pass        <= 1'b0;
      overflow    <= 1'b0;
      store_count <= '0;
    end else if (capture) begin
      if (store_count != 16'hFFFF) store_count <= store_count + 16'd1;
      // Full FIFO is always valid, so a ready consumer makes room this cycle.
      if (fifo_full && !trace_ready) overflow <= 1'b1;
      if (is_pass_store) begin
        state <= PASS;
        done  <= 1'b1;
        pass  <= 1'b1;
      end else if (dataadr != SCRATCH_ADDR) begin
        state <= FAIL;
        done  <= 1'b1;
        pass  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_store_trace_monitor.sv
// Directed bench for store_trace_monitor with a queue scoreboard of expected trace entries.
module tb_store_trace_monitor;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          memwrite = 1'b0;
  logic [31:0]   dataadr = '0;
  logic [31:0]   writedata = '0;
  logic          trace_ready = 1'b0;
  logic          trace_valid;
  logic [31:0]   trace_addr;
  logic [31:0]   trace_data;
  logic [CW-1:0] trace_count;
  logic          overflow;
  logic [15:0]   store_count;
  logic          done;
  logic          pass;

  store_trace_monitor #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .memwrite    (memwrite),
    .dataadr     (dataadr),
    .writedata   (writedata),
    .trace_valid (trace_valid),
    .trace_ready (trace_ready),
    .trace_addr  (trace_addr),
    .trace_data  (trace_data),
    .trace_count (trace_count),
    .overflow    (overflow),
    .store_count (store_count),
    .done        (done),
    .pass        (pass)
  );

  always #5 clk = ~clk;

  // Reference model
  logic [63:0] exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic        m_done, m_pass, m_ovf;
  int          m_sc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_done = 0; m_pass = 0; m_ovf = 0; m_sc = 0;
  endtask

  // Inputs change and outputs are sampled at the falling edge.
  task automatic do_reset(input int cycles, input logic noisy);
    reset = 1'b1;
    memwrite = noisy; dataadr = 32'd88; writedata = 32'd1; trace_ready = noisy;
    model_clear();
    repeat (cycles) @(negedge clk);
    reset = 1'b0; memwrite = 1'b0; trace_ready = 1'b0;
  endtask

  task automatic check_status(input string tag);
    chk({tag, ".count"}, 64'(trace_count), 64'(exp_q.size()));
    chk({tag, ".valid"}, 64'(trace_valid), 64'(exp_q.size() != 0));
    chk({tag, ".ovf"},   64'(overflow),    64'(m_ovf));
    chk({tag, ".sc"},    64'(store_count), 64'(m_sc));
    chk({tag, ".done"},  64'(done),        64'(m_done));
    chk({tag, ".pass"},  64'(pass),        64'(m_pass));
  endtask

  task automatic check_head(input string tag);
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, ".head_empty"}, {trace_addr, trace_data}, 64'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, ".head"}, {trace_addr, trace_data}, e);
    end
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic rdy);
    chk("pre_store.valid", 64'(trace_valid), 64'(exp_q.size() != 0));
    memwrite = 1'b1; dataadr = a; writedata = d; trace_ready = rdy;
    if (rdy && exp_q.size() != 0) check_head("store_pop");
    if (!m_done) begin
      if (m_sc < 65535) m_sc++;
      if (exp_q.size() < DEPTH) exp_q.push_back({a, d});
      else m_ovf = 1;
      if (a == 32'd84 && d == 32'd7) begin m_done = 1; m_pass = 1; end
      else if (a != 32'd80) begin m_done = 1; m_pass = 0; end
    end
    @(negedge clk);
    memwrite = 1'b0; trace_ready = 1'b0;
  endtask

  task automatic drain_one(input string tag);
    chk({tag, ".valid"}, 64'(trace_valid), 64'd1);
    check_head(tag);
    trace_ready = 1'b1;
    @(negedge clk);
    trace_ready = 1'b0;
  endtask

  task automatic drain_all(input string tag);
    while (exp_q.size() != 0) drain_one(tag);
    chk({tag, ".empty"}, 64'(trace_valid), 64'd0);
  endtask

  initial begin
    model_clear();
    @(negedge clk);
    do_reset(2, 1'b1);
    check_status("reset");
    check_head("reset");

    // Scratch store then pass store, consumer stalled
    do_store(32'd80, 32'd1, 1'b0);
    chk("first_store.done", 64'(done), 64'd0);
    do_store(32'd84, 32'd7, 1'b0);
    check_status("pass");
    drain_all("pass_drain");
    // Ready with nothing queued does nothing
    trace_ready = 1'b1;
    @(negedge clk);
    trace_ready = 1'b0;
    check_status("idle_ready");

    // Non-scratch address fails; later stores ignored
    do_reset(1, 1'b0);
    do_store(32'd88, 32'd5, 1'b0);
    check_status("fail_addr");
    do_store(32'd84, 32'd7, 1'b0);
    check_status("ignored");
    drain_all("fail_drain");

    // Pass address with wrong data fails
    do_reset(1, 1'b0);
    do_store(32'd84, 32'd6, 1'b0);
    check_status("fail_data");
    drain_all("fail_data_drain");

    // Overflow: nine scratch stores into eight entries
    do_reset(1, 1'b0);
    for (int i = 0; i < 9; i++) do_store(32'd80, 32'(i + 16), 1'b0);
    check_status("overflow");
    drain_all("ovf_drain");
    check_status("ovf_after");

    // Full FIFO with simultaneous pop and push
    do_reset(1, 1'b0);
    for (int i = 0; i < 8; i++) do_store(32'd80, 32'(i + 32), 1'b0);
    check_status("full");
    do_store(32'd80, 32'd9, 1'b1);
    check_status("full_pushpop");
    drain_all("pushpop_drain");

    // Reset while FAIL with entries queued and a store/pop in flight
    do_reset(1, 1'b0);
    do_store(32'd80, 32'd1, 1'b0);
    do_store(32'd80, 32'd2, 1'b0);
    do_store(32'd88, 32'd3, 1'b0);
    check_status("pre_reset");
    do_reset(1, 1'b1);
    check_status("mid_reset");
    check_head("mid_reset");
    // Back in RUN: a fresh pass store is accepted
    do_store(32'd84, 32'd7, 1'b0);
    check_status("after_reset");
    drain_all("after_reset_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/store_trace_monitor.md
STORE_TRACE_MONITOR -- requirements
Module: store_trace_monitor

Interface
REQ-001 SHALL have parameter DEPTH, default 8, trace FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter PASS_ADDR, default 32'd84, address whose store decides pass.
REQ-003 SHALL have parameter PASS_DATA, default 32'd7, data value required at PASS_ADDR for pass.
REQ-004 SHALL have parameter SCRATCH_ADDR, default 32'd80, address whose stores are tolerated before verdict.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port memwrite  input  1  processor data-memory write strobe, one store per cycle high.
REQ-008 SHALL have port dataadr  input  32  store byte address, valid when memwrite=1.
REQ-009 SHALL have port writedata  input  32  store data, valid when memwrite=1.
REQ-010 SHALL have port trace_valid  output  1  FIFO head holds an entry.
REQ-011 SHALL have port trace_ready  input  1  consumer accepts head entry this cycle.
REQ-012 SHALL have port trace_addr  output  32  head entry address.
REQ-013 SHALL have port trace_data  output  32  head entry data.
REQ-014 SHALL have port trace_count  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-015 SHALL have port overflow  output  1  sticky: a store was dropped because FIFO was full.
REQ-016 SHALL have port store_count  output  16  stores captured in RUN, saturating at 16'hFFFF.
REQ-017 SHALL have port done  output  1  verdict reached.
REQ-018 SHALL have port pass  output  1  verdict is pass; fail = done & ~pass.

Function
REQ-019 Verdict FSM SHALL have states RUN, PASS, FAIL; PASS and FAIL are terminal until reset.
REQ-020 In RUN, memwrite with dataadr==PASS_ADDR and writedata==PASS_DATA SHALL go to PASS next edge.
REQ-021 In RUN, memwrite with dataadr!=SCRATCH_ADDR, excluding the REQ-020 case, SHALL go to FAIL next edge (includes PASS_ADDR with wrong data).
REQ-022 In RUN, memwrite with dataadr==SCRATCH_ADDR SHALL stay in RUN.
REQ-023 done SHALL be 1 in PASS or FAIL; pass SHALL be 1 only in PASS; both registered (visible the cycle after the deciding store).
REQ-024 Push SHALL occur when memwrite=1 and state==RUN (the deciding store is captured); stores in PASS/FAIL SHALL be ignored entirely.
REQ-025 Pop SHALL occur when trace_valid & trace_ready; trace_ready with trace_valid=0 SHALL have no effect.
REQ-026 trace_addr/trace_data SHALL show the head entry combinationally from storage (show-ahead); undefined-safe value 0 when empty.
REQ-027 Push-to-visible latency SHALL be 1 cycle; no same-cycle bypass when empty.
REQ-028 Simultaneous push and pop SHALL both take effect, count unchanged, including when full.
REQ-029 Push when full without pop SHALL drop the store, set overflow, leave FIFO unchanged; store_count and FSM still update.
REQ-030 Pointers SHALL be $clog2(DEPTH)+1 bits with wrap-around; full = MSBs differ, low bits equal; empty = equal.
REQ-031 store_count SHALL increment on each memwrite in RUN, saturating, independent of FIFO drop.

Reset
REQ-032 reset=1 at a rising edge SHALL set state RUN, pointers 0, trace_count 0, trace_valid 0, overflow 0, store_count 0, done 0, pass 0.
REQ-033 reset SHALL override any simultaneous push, pop or verdict; FIFO contents discarded mid-operation.
REQ-034 memwrite during reset SHALL be ignored.

Structure
REQ-035 Package store_trace_pkg SHALL hold the verdict_state_t enum (RUN, PASS, FAIL) and the trace entry struct (addr, data).
REQ-036 FIFO storage/pointers SHALL be a sub-module trace_fifo (synchronous, one clock, parameter DEPTH); verdict FSM and counters live in store_trace_monitor.

Verification
REQ-037 Reset 2 cycles, then store (80,1),(84,7), trace_ready=0 -> done=1,pass=1 after second store; trace_count=2; heads (80,1) then (84,7) on draining.
REQ-038 Store (88,5) from RUN -> done=1,pass=0 next cycle; later (84,7) ignored, store_count stays 1.
REQ-039 Store (84,6) -> FAIL; trace entry (84,6) captured.
REQ-040 DEPTH=8, 9 stores to addr 80, trace_ready=0 -> trace_count=8, overflow=1, store_count=9, first 8 drained in order.
REQ-041 FIFO full, push (80,9) with trace_ready=1 same cycle -> overflow stays 0, count stays 8, (80,9) is last entry out.
REQ-042 Assert reset with 3 entries queued and state FAIL -> next cycle all outputs 0, state RUN, trace_valid=0.
